iomem_arbiter: RTL and testbench

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

---
 rtl/iomem_arbiter.sv | 125 ++++++++++++
 tb/tb_iomem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// iomem_arbiter
//   Two-master, one-slave arbiter for a valid/ready memory bus.
//   Round-robin grant, registered slave request held stable while BUSY,
//   bounded slave wait with an error-data completion on timeout.
//
// Ports
//   clk                     rising-edge clock
//   resetn                  asynchronous active-low reset
//   m0_*/m1_*               master request (valid/addr/wdata/wstrb) and
//                           response (rdata/ready pulse)
//   s_valid/s_addr/s_wdata/s_wstrb   shared-slave request (registered)
//   s_rdata/s_ready         shared-slave response
//   timeout                 one-cycle pulse when a transfer is aborted
//   err_count               saturating count of timeouts
module iomem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        timeout,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       grant;       // master owning the current transfer
  logic       last_grant;  // master granted most recently
  logic [7:0] wait_cnt;
  logic       pick;

  // Contention goes to the master not served last; a lone requester wins.
  always_comb begin
    pick = 1'b0;
    if (m0_valid && m1_valid) pick = ~last_grant;
    else if (m1_valid)        pick = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      s_valid    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            s_valid    <= 1'b1;
            s_addr     <= pick ? m1_addr  : m0_addr;
            s_wdata    <= pick ? m1_wdata : m0_wdata;
            s_wstrb    <= pick ? m1_wstrb : m0_wstrb;
            wait_cnt   <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // A response on the final wait cycle still counts as a normal completion.
          if (s_ready) begin
            if (grant) m1_rdata <= s_rdata;
            else       m0_rdata <= s_rdata;
            m0_ready <= ~grant;
            m1_ready <= grant;
            s_valid  <= 1'b0;
            state    <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            if (grant) m1_rdata <= ERR_DATA;
            else       m0_rdata <= ERR_DATA;
            m0_ready <= ~grant;
            m1_ready <= grant;
            timeout  <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            s_valid  <= 1'b0;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = '0;
  logic        s_ready = 1'b0;
  logic        timeout;
  logic [7:0]  err_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  iomem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .timeout(timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the grant edge; holds s_ready low for 'waits' BUSY
  // cycles, then responds. Returns just after the capture edge (RESP cycle).
  task automatic slave_resp(input int unsigned waits, input logic [31:0] data);
    for (int unsigned i = 0; i < waits; i++) begin
      chk("busy_no_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      chk("busy_s_valid", {31'd0, s_valid}, 32'd1);
      tick();
    end
    s_rdata = data;
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
  endtask

  initial begin
    // ---- reset state
    #2 resetn = 1'b0;
    #1;
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    // ---- m0 read, 1-cycle slave: s_valid at +1, ready at +3
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'b0000;
    tick();
    chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
    chk("t1_s_addr", s_addr, 32'h10);
    chk("t1_s_wstrb", {28'd0, s_wstrb}, 32'd0);
    tick();
    chk("t1_no_ready_c2", {30'd0, m1_ready, m0_ready}, 32'd0);
    s_rdata = 32'h12345678; s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("t1_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t1_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("t1_m0_rdata", m0_rdata, 32'h12345678);
    chk("t1_s_valid_off", {31'd0, s_valid}, 32'd0);
    m0_valid = 1'b0;
    tick();
    chk("t1_ready_once", {31'd0, m0_ready}, 32'd0);
    chk("t1_rdata_hold", m0_rdata, 32'h12345678);
    tick();
    chk("t1_no_regrant", {31'd0, s_valid}, 32'd0);

    // ---- m1 write, 2 wait cycles: request stable through BUSY
    m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'b0011;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3_s_valid", {31'd0, s_valid}, 32'd1);
      chk("t3_s_wstrb", {28'd0, s_wstrb}, 32'h3);
      chk("t3_s_wdata", s_wdata, 32'hA5A5A5A5);
      chk("t3_s_addr", s_addr, 32'h20);
      if (i == 2) begin
        s_rdata = 32'h0; s_ready = 1'b1;
      end
      tick();
    end
    s_ready = 1'b0;
    chk("t3_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("t3_m0_ready", {31'd0, m0_ready}, 32'd0);
    m1_valid = 1'b0; m1_wstrb = 4'b0000;
    tick();

    // ---- simultaneous pair after an m1 grant: m0 first, then m1
    m0_valid = 1'b1; m0_addr = 32'h100;
    m1_valid = 1'b1; m1_addr = 32'h200;
    tick();
    chk("p1_first_addr", s_addr, 32'h100);
    slave_resp(1, 32'h11111111);
    chk("p1_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("p1_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("p1_m0_rdata", m0_rdata, 32'h11111111);
    m0_valid = 1'b0;
    tick();
    chk("p1_idle_gap", {31'd0, s_valid}, 32'd0);
    tick();
    chk("p1_second_addr", s_addr, 32'h200);
    slave_resp(1, 32'h22222222);
    chk("p1_m1_ready2", {31'd0, m1_ready}, 32'd1);
    chk("p1_m0_ready2", {31'd0, m0_ready}, 32'd0);
    chk("p1_m1_rdata", m1_rdata, 32'h22222222);
    chk("p1_m0_rdata_hold", m0_rdata, 32'h11111111);
    m1_valid = 1'b0;
    tick();

    m0_valid = 1'b1; m0_addr = 32'h300;
    m1_valid = 1'b1; m1_addr = 32'h400;
    tick();
    chk("p2_first_addr", s_addr, 32'h300);
    slave_resp(0, 32'h33333333);
    chk("p2_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("p2_m1_ready", {31'd0, m1_ready}, 32'd0);
    m0_valid = 1'b0;
    tick();
    tick();
    chk("p2_second_addr", s_addr, 32'h400);
    slave_resp(0, 32'h44444444);
    chk("p2_m1_ready2", {31'd0, m1_ready}, 32'd1);
    chk("p2_m1_rdata", m1_rdata, 32'h44444444);
    m1_valid = 1'b0;
    tick();

    // ---- timeout: slave never ready, 4 BUSY cycles then error completion
    m0_valid = 1'b1; m0_addr = 32'h40;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_busy_s_valid", {31'd0, s_valid}, 32'd1);
      chk("to_busy_ready", {31'd0, m0_ready}, 32'd0);
      chk("to_busy_timeout", {31'd0, timeout}, 32'd0);
      tick();
    end
    chk("to_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("to_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_err1", {24'd0, err_count}, 32'd1);
    chk("to_s_valid_off", {31'd0, s_valid}, 32'd0);
    m0_valid = 1'b0;
    tick();
    chk("to_pulse_once", {31'd0, timeout}, 32'd0);

    // ---- response on the last wait cycle: normal completion
    m0_valid = 1'b1; m0_addr = 32'h44;
    tick();
    slave_resp(3, 32'hCAFEF00D);
    chk("edge_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("edge_rdata", m0_rdata, 32'hCAFEF00D);
    chk("edge_no_timeout", {31'd0, timeout}, 32'd0);
    chk("edge_err_same", {24'd0, err_count}, 32'd1);
    m0_valid = 1'b0;
    tick();
    chk("edge_no_timeout2", {31'd0, timeout}, 32'd0);

    // ---- saturation: 300 timeouts in total
    repeat (99) begin
      m0_valid = 1'b1;
      tick();
      repeat (4) tick();
      m0_valid = 1'b0;
      tick();
    end
    chk("sat_err100", {24'd0, err_count}, 32'd100);
    repeat (200) begin
      m0_valid = 1'b1;
      tick();
      repeat (4) tick();
      m0_valid = 1'b0;
      tick();
    end
    chk("sat_err255", {24'd0, err_count}, 32'd255);

    // ---- reset during BUSY
    m1_valid = 1'b1; m1_addr = 32'h50;
    tick();
    chk("rb_s_valid", {31'd0, s_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rb_s_valid_drop", {31'd0, s_valid}, 32'd0);
    chk("rb_s_addr", s_addr, 32'd0);
    chk("rb_err", {24'd0, err_count}, 32'd0);
    m1_valid = 1'b0;
    s_rdata = 32'h99999999; s_ready = 1'b1;
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rb_no_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      chk("rb_idle", {31'd0, s_valid}, 32'd0);
    end
    s_ready = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h60;
    tick();
    chk("rb_next_addr", s_addr, 32'h60);
    slave_resp(1, 32'h00000077);
    chk("rb_next_ready", {31'd0, m1_ready}, 32'd1);
    chk("rb_next_rdata", m1_rdata, 32'h00000077);
    m1_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
